fpu_req_dispatcher: RTL

// - Upstream feeder for the FP add/sub unit (start/op/data_a/data_b in; busy/ready/data_o out).
// - Buffers add/sub requests in a FIFO and issues one start pulse per request to the FPU.
// - Captures each FPU result and presents it on a valid/ready result port.
// - Lets producers stream requests without tracking FPU busy timing.

---
 rtl/fpu_req_dispatcher.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_req_dispatcher.sv
// Request FIFO and issue sequencer in front of a single-issue FP add/sub unit.
// Define FPU_TIMEOUT_EN to add a WAIT-state watchdog that substitutes a quiet NaN with res_err=1.
module fpu_req_dispatcher #(
  parameter int DEPTH       = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_op,
  input  logic [DATA_W-1:0]        i_req_a,
  input  logic [DATA_W-1:0]        i_req_b,
  output logic                     o_fpu_start,
  output logic                     o_fpu_op,
  output logic [DATA_W-1:0]        o_fpu_a,
  output logic [DATA_W-1:0]        o_fpu_b,
  input  logic                     i_fpu_busy,
  input  logic                     i_fpu_ready,
  input  logic [DATA_W-1:0]        i_fpu_data,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic [DATA_W-1:0]        o_res_data,
  output logic                     o_res_err,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DEPTH-1:0]    r_mem_op;
  logic [DATA_W-1:0]   r_mem_a [DEPTH];
  logic [DATA_W-1:0]   r_mem_b [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic                r_fpu_op;
  logic [DATA_W-1:0]   r_fpu_a;
  logic [DATA_W-1:0]   r_fpu_b;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_data;
  logic                w_push;
  logic                w_pop;
  logic                w_capture;

`ifdef FPU_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] QNAN     = DATA_W'(32'h7FC0_0000);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_res_err;
  logic          w_timeout;
`endif

  assign o_req_ready  = (r_count != (AW+1)'(DEPTH));
  assign w_push       = i_req_valid && o_req_ready;
  assign o_fifo_count = r_count;
  assign o_fpu_start  = (r_state == ISSUE);
  assign o_fpu_op     = r_fpu_op;
  assign o_fpu_a      = r_fpu_a;
  assign o_fpu_b      = r_fpu_b;
  assign o_res_valid  = r_res_valid;
  assign o_res_data   = r_res_data;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Pop happens on the IDLE->ISSUE transition; the FPU result is only looked at in WAIT.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
`ifdef FPU_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (r_count != '0 && !i_fpu_busy && !r_res_valid) begin
          w_pop  = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (i_fpu_ready) begin
          w_capture = 1'b1;
          w_next    = HOLD;
        end
`ifdef FPU_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = HOLD;
        end
`endif
      end
      HOLD: begin
        if (i_res_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr] <= i_req_op;
      r_mem_a[r_wr_ptr]  <= i_req_a;
      r_mem_b[r_wr_ptr]  <= i_req_b;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operands stay registered until the next pop, so they are stable for the whole transaction.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fpu_op <= 1'b0;
      r_fpu_a  <= '0;
      r_fpu_b  <= '0;
    end else if (w_pop) begin
      r_fpu_op <= r_mem_op[r_rd_ptr];
      r_fpu_a  <= r_mem_a[r_rd_ptr];
      r_fpu_b  <= r_mem_b[r_rd_ptr];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_data  <= i_fpu_data;
    end
`ifdef FPU_TIMEOUT_EN
    else if (w_timeout) begin
      r_res_valid <= 1'b1;
      r_res_data  <= QNAN;
    end
`endif
    else if (r_state == HOLD && i_res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

`ifdef FPU_TIMEOUT_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tmo_cnt <= '0;
      r_res_err <= 1'b0;
    end else begin
      if (r_state == ISSUE)     r_tmo_cnt <= '0;
      else if (r_state == WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_capture)      r_res_err <= 1'b0;
      else if (w_timeout) r_res_err <= 1'b1;
    end
  end

  assign o_res_err = r_res_err;
`else
  assign o_res_err = 1'b0;
`endif

endmodule
